// File: rtl/ushift_pkg.sv
// Shared encodings for the universal shift register: operation selects and
// sequencer states.
package ushift_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_CMP  = 3'b001;
  localparam logic [2:0] OP_ZERO = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_ROL  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ushift_step.sv
// Combinational next-value function for one register step. Used by both
// single-cycle operations and every step of a multi-step sequence.
module ushift_step
  import ushift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_par,
  input  logic             i_msb,
  input  logic             i_lsb,
  output logic [WIDTH-1:0] o_next
);

  always_comb begin
    o_next = i_a;
    case (i_sel)
      OP_HOLD: o_next = i_a;
      OP_CMP:  o_next = ~i_a;
      OP_ZERO: o_next = '0;
      OP_LOAD: o_next = i_par;
      OP_SHR:  o_next = {i_msb, i_a[WIDTH-1:1]};
      OP_SHL:  o_next = {i_a[WIDTH-2:0], i_lsb};
      OP_ROR:  o_next = {i_a[0], i_a[WIDTH-1:1]};
      OP_ROL:  o_next = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
      default: o_next = i_a;
    endcase
  end

endmodule

// File: rtl/ushift_n.sv
// Universal WIDTH-bit shift register with a multi-step shift/rotate sequencer.
// Handshake: start with sel[2]=1 is accepted only in IDLE; busy is high while
// further steps remain and done pulses for one cycle as busy returns to 0.
module ushift_n
  import ushift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] i_par,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] a_par,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [2:0]       w_op_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_step;

  // The first step of a sequence runs on the start edge using live sel,
  // which is the same value being latched into r_op.
  assign w_op = (r_state == ST_RUN) ? r_op : sel;

  ushift_step #(.WIDTH(WIDTH)) u_step (
    .i_sel  (w_op),
    .i_a    (r_a),
    .i_par  (i_par),
    .i_msb  (msb_in),
    .i_lsb  (lsb_in),
    .o_next (w_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = w_step;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && sel[2]) begin
          w_op_nxt = sel;
          if (amount == '0) begin
            w_a_nxt    = r_a;
            w_done_nxt = 1'b1;
          end else if (amount == CNT_W'(1)) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = amount - CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_op    <= OP_HOLD;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign a_par   = r_a;
  assign msb_out = r_a[WIDTH-1];
  assign lsb_out = r_a[0];
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_ushift_n.sv
// Self-checking bench for ushift_n: a cycle model pushes expected outputs to a
// queue before each edge; they are popped and compared one time unit after it.
module tb_ushift_n;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clear;
  logic [2:0]    sel;
  logic [W-1:0]  i_par;
  logic          msb_in;
  logic          lsb_in;
  logic          start;
  logic [CW-1:0] amount;
  logic [W-1:0]  a_par;
  logic          msb_out;
  logic          lsb_out;
  logic          busy;
  logic          done;

  ushift_n #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .clear   (clear),
    .sel     (sel),
    .i_par   (i_par),
    .msb_in  (msb_in),
    .lsb_in  (lsb_in),
    .start   (start),
    .amount  (amount),
    .a_par   (a_par),
    .msb_out (msb_out),
    .lsb_out (lsb_out),
    .busy    (busy),
    .done    (done)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state
  logic [W+3:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int n_busy   = 0;

  // reference model state
  logic [W-1:0]  m_a    = '0;
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [2:0]    m_op   = 3'b000;
  int            m_rem  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_step(input logic [2:0] s, input logic [W-1:0] a,
                                            input logic [W-1:0] p, input logic mi,
                                            input logic li);
    logic [W-1:0] r;
    case (s)
      3'd0: r = a;
      3'd1: r = ~a;
      3'd2: r = '0;
      3'd3: r = p;
      3'd4: r = (a >> 1) | (W'(mi) << (W - 1));
      3'd5: r = (a << 1) | W'(li);
      3'd6: r = (a >> 1) | (a << (W - 1));
      default: r = (a << 1) | (a >> (W - 1));
    endcase
    return r;
  endfunction

  task automatic model_edge();
    if (clear) begin
      m_a = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_op = 3'b000;
    end else if (m_busy) begin
      m_a   = ref_step(m_op, m_a, i_par, msb_in, lsb_in);
      m_rem = m_rem - 1;
      m_done = (m_rem == 0);
      if (m_rem == 0) m_busy = 1'b0;
    end else if (start && sel[2]) begin
      m_op = sel;
      m_done = 1'b0;
      if (amount == 0) m_done = 1'b1;
      else begin
        m_a = ref_step(sel, m_a, i_par, msb_in, lsb_in);
        if (amount == 1) m_done = 1'b1;
        else begin
          m_busy = 1'b1;
          m_rem  = int'(amount) - 1;
        end
      end
    end else begin
      m_a    = ref_step(sel, m_a, i_par, msb_in, lsb_in);
      m_done = 1'b0;
    end
  endtask

  task automatic tick();
    logic [W+3:0] e;
    model_edge();
    exp_q.push_back({m_a[0], m_a[W-1], m_done, m_busy, m_a});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_a_par",   32'(a_par),   32'(e[W-1:0]));
    check("sb_busy",    32'(busy),    32'(e[W]));
    check("sb_done",    32'(done),    32'(e[W+1]));
    check("sb_msb_out", 32'(msb_out), 32'(e[W+2]));
    check("sb_lsb_out", 32'(lsb_out), 32'(e[W+3]));
    if (done) n_done++;
    if (busy) n_busy++;
  endtask

  // driver: apply one cycle of inputs and advance one edge
  task automatic drive(input logic c, input logic [2:0] s, input logic [W-1:0] p,
                       input logic mi, input logic li, input logic st,
                       input logic [CW-1:0] am);
    clear = c; sel = s; i_par = p; msb_in = mi; lsb_in = li; start = st; amount = am;
    tick();
  endtask

  task automatic op(input logic [2:0] s, input logic [W-1:0] p);
    drive(1'b0, s, p, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    clear = 1'b0; sel = 3'b000; i_par = '0; msb_in = 1'b0; lsb_in = 1'b0;
    start = 1'b0; amount = '0;

    // 1: reset and basic ops
    drive(1'b1, 3'b000, '0, 1'b0, 1'b0, 1'b0, '0);
    check("t1_reset_a", 32'(a_par), 32'h00);
    check("t1_reset_busy", 32'(busy), 32'h0);
    check("t1_reset_done", 32'(done), 32'h0);
    op(3'b011, 8'hB5); check("t1_load", 32'(a_par), 32'hB5);
    op(3'b001, 8'h00); check("t1_cmp", 32'(a_par), 32'h4A);
    op(3'b010, 8'h00); check("t1_zero", 32'(a_par), 32'h00);

    // 2: serial shift
    op(3'b011, 8'h81);
    drive(1'b0, 3'b100, '0, 1'b1, 1'b0, 1'b0, '0); check("t2_shr", 32'(a_par), 32'hC0);
    drive(1'b0, 3'b101, '0, 1'b0, 1'b0, 1'b0, '0); check("t2_shl", 32'(a_par), 32'h80);
    check("t2_msb_out", 32'(msb_out), 32'h1);
    check("t2_lsb_out", 32'(lsb_out), 32'h0);

    // 3: three-step rotate left; sel changed to zero while busy
    op(3'b011, 8'h81);
    n_busy = 0; n_done = 0;
    drive(1'b0, 3'b111, '0, 1'b0, 1'b0, 1'b1, 4'd3); check("t3_step1", 32'(a_par), 32'h03);
    drive(1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b0, '0);   check("t3_step2", 32'(a_par), 32'h06);
    drive(1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b0, '0);   check("t3_step3", 32'(a_par), 32'h0C);
    check("t3_done", 32'(done), 32'h1);
    op(3'b000, '0);
    check("t3_busy_cycles", 32'(n_busy), 32'd2);
    check("t3_done_pulses", 32'(n_done), 32'd1);

    // 4: boundaries
    op(3'b011, 8'h5A);
    n_busy = 0; n_done = 0;
    drive(1'b0, 3'b110, '0, 1'b0, 1'b0, 1'b1, 4'd0);
    check("t4_n0_a", 32'(a_par), 32'h5A);
    check("t4_n0_done", 32'(done), 32'h1);
    op(3'b000, '0);
    check("t4_n0_busy_never", 32'(n_busy), 32'd0);
    drive(1'b0, 3'b110, '0, 1'b0, 1'b0, 1'b1, 4'd9);
    for (int i = 0; i < 8; i++) drive(1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b0, '0);
    check("t4_n9_a", 32'(a_par), 32'h2D);
    check("t4_n9_done", 32'(done), 32'h1);
    op(3'b000, '0);

    // 5: clear in the middle of a 10-step shift left
    op(3'b011, 8'h01);
    n_done = 0;
    drive(1'b0, 3'b101, '0, 1'b0, 1'b1, 1'b1, 4'd10); check("t5_e1", 32'(a_par), 32'h03);
    drive(1'b0, 3'b000, '0, 1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 3'b000, '0, 1'b0, 1'b1, 1'b0, '0);   check("t5_e3", 32'(a_par), 32'h0F);
    drive(1'b1, 3'b000, '0, 1'b0, 1'b1, 1'b0, '0);
    check("t5_clear_a", 32'(a_par), 32'h00);
    check("t5_clear_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 12; i++) op(3'b000, '0);
    check("t5_no_done", 32'(n_done), 32'd0);
    op(3'b011, 8'h3C); check("t5_after_load", 32'(a_par), 32'h3C);

    // 6: back-to-back two-step shift right
    op(3'b011, 8'hF0);
    n_done = 0;
    drive(1'b0, 3'b100, '0, 1'b0, 1'b0, 1'b1, 4'd2); check("t6_a1", 32'(a_par), 32'h78);
    drive(1'b0, 3'b100, '0, 1'b0, 1'b0, 1'b0, '0);   check("t6_a2", 32'(a_par), 32'h3C);
    check("t6_done1", 32'(done), 32'h1);
    drive(1'b0, 3'b100, '0, 1'b0, 1'b0, 1'b1, 4'd2); check("t6_a3", 32'(a_par), 32'h1E);
    check("t6_busy2", 32'(busy), 32'h1);
    drive(1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, '0);   check("t6_a4", 32'(a_par), 32'h0F);
    op(3'b000, '0);
    check("t6_done_pulses", 32'(n_done), 32'd2);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) == 0), 3'($urandom_range(0, 7)), W'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), CW'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
